// File: rtl/gpio_sched_pkg.sv
// Shared types for the GPIO bank scheduler: FSM states, grant sources and
// the reset value of the write/read alternation flag.
package gpio_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RWAIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_WR   = 2'd0,
        SRC_RD   = 2'd1,
        SRC_SCAN = 2'd2
    } src_t;

    // 1 means "last grant went to input b" (the read port), so a tie after reset goes to a.
    localparam logic LAST_RESET = 1'b1;

endpackage

// File: rtl/gpio_rr_arb.sv
// Two-input alternating arbiter. Grants are combinational; the alternation flag
// only moves when advance is high and one of the inputs is actually granted.
module gpio_rr_arb
    import gpio_sched_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic grant_a,
    output logic grant_b
);

    logic last_b;

    always_comb begin
        grant_a = req_a & (~req_b | last_b);
        grant_b = req_b & (~req_a | ~last_b);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_b <= LAST_RESET;
        end else if (advance && (grant_a || grant_b)) begin
            last_b <= grant_b;
        end
    end

endmodule

// File: rtl/gpio_bank_scheduler.sv
// Shares the single GPIO bank bus between host writes, host reads and a
// background round-robin scan of the input registers; one access at a time.
module gpio_bank_scheduler
    import gpio_sched_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int          AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_ack,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             err,
    input  logic             scan_en,
    output logic             scan_valid,
    output logic [AW-1:0]    scan_addr,
    output logic [WIDTH-1:0] scan_data,
    output logic             busy,
    output logic             bank_sel,
    output logic             bank_wen,
    output logic             bank_ren,
    output logic [AW-1:0]    bank_addr,
    output logic [WIDTH-1:0] bank_wdata,
    input  logic [WIDTH-1:0] bank_rdata,
    output logic [1:0]       state_dbg
);

    // Handshake: wr_req/rd_req are held until their one-cycle ack; a request still
    // high in the next IDLE cycle is treated as a fresh request.

    state_t        state;
    src_t          src;
    logic          rd_oob;
    logic [AW-1:0] scan_ptr;
    logic          grant_wr;
    logic          grant_rd;
    logic          wr_in_range;
    logic          rd_in_range;

    assign wr_in_range = (32'(wr_addr) < N);
    assign rd_in_range = (32'(rd_addr) < N);
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

    gpio_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_a   (wr_req),
        .req_b   (rd_req),
        .advance (state == IDLE),
        .grant_a (grant_wr),
        .grant_b (grant_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src        <= SRC_WR;
            rd_oob     <= 1'b0;
            scan_ptr   <= '0;
            wr_ack     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            err        <= 1'b0;
            scan_valid <= 1'b0;
            scan_addr  <= '0;
            scan_data  <= '0;
            bank_sel   <= 1'b0;
            bank_wen   <= 1'b0;
            bank_ren   <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
        end else begin
            // Pulses and strobes default low; address and write data hold.
            wr_ack     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            scan_valid <= 1'b0;
            err        <= 1'b0;
            bank_sel   <= 1'b0;
            bank_wen   <= 1'b0;
            bank_ren   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        state      <= WRITE;
                        src        <= SRC_WR;
                        wr_ack     <= 1'b1;
                        err        <= ~wr_in_range;
                        bank_sel   <= wr_in_range;
                        bank_wen   <= wr_in_range;
                        bank_addr  <= wr_addr;
                        bank_wdata <= wr_data;
                    end else if (grant_rd) begin
                        state     <= READ;
                        src       <= SRC_RD;
                        rd_ack    <= 1'b1;
                        err       <= ~rd_in_range;
                        rd_oob    <= ~rd_in_range;
                        bank_sel  <= rd_in_range;
                        bank_ren  <= rd_in_range;
                        bank_addr <= rd_addr;
                    end else if (scan_en) begin
                        state     <= READ;
                        src       <= SRC_SCAN;
                        rd_oob    <= 1'b0;
                        bank_sel  <= 1'b1;
                        bank_ren  <= 1'b1;
                        bank_addr <= scan_ptr;
                    end
                end
                WRITE: state <= IDLE;
                READ:  state <= RWAIT;
                RWAIT: begin
                    state <= IDLE;
                    if (src == SRC_SCAN) begin
                        scan_valid <= 1'b1;
                        scan_addr  <= scan_ptr;
                        scan_data  <= bank_rdata;
                        scan_ptr   <= (scan_ptr == AW'(N - 1)) ? '0 : scan_ptr + 1'b1;
                    end else begin
                        rd_valid <= 1'b1;
                        rd_data  <= rd_oob ? '0 : bank_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gpio_bank_scheduler.md
# gpio_bank_scheduler

Sequencing controller for the fast-GPIO register bank. It replaces the free-running address counter with an arbiter that shares the single bank bus (sel/wen/ren/addr/data) among three requesters:
- a host write port;
- a host read port;
- a background round-robin scan of the input registers.

It sits between the host-side logic and the grouped gpio_out/gpio_in register banks. It issues at most one bank access at a time.

## Interface
Parameters:
- WIDTH, 32, data width of every bank register
- N, 4, number of registers per bank (1..256, need not be a power of 2)
- AW, 2, address width; must satisfy 2**AW >= N

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset; one clock, no other clock domains
- wr_req  in  1  host write request; held until wr_ack
- wr_addr  in  AW  write register index
- wr_data  in  WIDTH  write data
- wr_ack  out  1  one-cycle grant pulse for the write
- rd_req  in  1  host read request; held until rd_ack
- rd_addr  in  AW  read register index
- rd_ack  out  1  one-cycle grant pulse for the read
- rd_valid  out  1  one-cycle pulse; rd_data is valid
- rd_data  out  WIDTH  read result
- err  out  1  one-cycle pulse: granted address >= N
- scan_en  in  1  enables the background input scan
- scan_valid  out  1  one-cycle pulse; scan_addr/scan_data are valid
- scan_addr  out  AW  register index of the scan result
- scan_data  out  WIDTH  scan result
- busy  out  1  high whenever state != IDLE
- bank_sel, bank_wen, bank_ren  out  1  bank strobes
- bank_addr  out  AW  bank register index
- bank_wdata  out  WIDTH  data to the out-bank
- bank_rdata  in  WIDTH  data from the in-bank; valid one cycle after bank_ren

## Operation
- FSM states: IDLE, WRITE, READ, RWAIT.
- In IDLE, pick one requester per cycle, in this priority order:
  1. host write or host read, chosen by a 2-way alternating arbiter;
  2. scan, only if scan_en=1 and no host request is pending.
- Alternating arbiter: `last` flag resets to "read", so a simultaneous first request grants the write. After each host grant, `last` = the granted side.
- IDLE→WRITE (write granted): bank_sel=bank_wen=1, bank_addr=wr_addr, bank_wdata=wr_data, wr_ack=1. WRITE→IDLE.
- IDLE→READ (host read or scan granted): bank_sel=bank_ren=1, bank_addr = rd_addr or scan_ptr. rd_ack=1 for host reads only. READ→RWAIT.
- RWAIT: capture bank_rdata.
  - Host read: drive rd_data and pulse rd_valid.
  - Scan: drive scan_data, scan_addr and pulse scan_valid; scan_ptr advances (N-1 wraps to 0).
  - RWAIT→IDLE.
- Address >= N: the request is still acked and the normal state sequence runs, but bank_sel/bank_wen/bank_ren stay 0 and err pulses with the ack. A read returns rd_data=0 with rd_valid.
- scan_en dropping mid-scan: the in-flight scan completes; no new scan starts.
- All bank_* strobes are 0 outside WRITE/READ. bank_addr and bank_wdata hold their last value.

## Timing
- Outputs are registered. The grant decision made in IDLE at edge t drives the bus and ack in cycle t+1.
- Write: request sampled at t → wr_ack and bank write in t+1 → IDLE at t+2. Peak throughput is 1 write per 2 cycles.
- Read: request sampled at t → rd_ack and bank_ren in t+1 → rd_valid in t+3. One read per 3 cycles.
- A requester must not deassert req before its ack. Holding req after the ack counts as a new request at the next IDLE.
- Reset: state=IDLE, scan_ptr=0, last=read. Every output is 0 (strobes, acks, valids, err, busy, rd_data, scan_data, scan_addr, bank_addr, bank_wdata).
- Reset asserted mid-operation aborts the access. No ack, valid or err pulse follows the reset edge.

## Structure
- Package gpio_sched_pkg holds:
  - the state enum (IDLE, WRITE, READ, RWAIT);
  - the grant-source encoding (SRC_WR, SRC_RD, SRC_SCAN);
  - the reset value of `last`.
- Sub-module gpio_rr_arb: 2-input alternating arbiter (req_a, req_b, advance → grant_a, grant_b), with `last` reset to favour input a. It is instantiated once for write vs read. Scan priority is applied outside it.
- Top level contains the FSM, scan_ptr with wrap at N-1, and the output registers.

## Test plan
- Reset, then wr_req with wr_addr=2, wr_data=0xDEADBEEF → wr_ack and bank_wen with bank_addr=2 exactly one cycle later; busy=1 for 1 cycle.
- rd_req with rd_addr=1, bank_rdata=0x12345678 presented in RWAIT → rd_ack at t+1, rd_valid with rd_data=0x12345678 at t+3.
- wr_req and rd_req raised together and held → grants alternate W,R,W,R, starting with W after reset.
- scan_en=1, N=3, no host traffic → scan_addr sequence 0,1,2,0,… with a scan_valid every 3 cycles. A host rd_req arriving mid-scan is granted at the next IDLE, ahead of the next scan.
- N=3, rd_addr=3 → rd_ack and err pulse, no bank_ren, rd_valid with rd_data=0.
- Assert reset during RWAIT → no rd_valid follows; all outputs read 0 on the next cycle; scan restarts at addr 0.
